// File: rtl/sseg_pkg.sv
// Shared constants, digit-word field positions and FSM state type for the
// seven-segment BCD formatter.
package sseg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 6;
  localparam logic [26:0] MAX_DEC = 27'd99_999_999;

  // Digit word layout: {en, bcd[3:0], dp}
  localparam int EN_BIT  = 5;
  localparam int BCD_MSB = 4;
  localparam int BCD_LSB = 1;
  localparam int DP_BIT  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2,
    DONE   = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/sseg_bcd_formatter_if.sv
// Request/result bundle between a producer of binary values and the formatter.
//
// Handshake: the master raises start with bin/dp_mask/blank_en valid; the
// formatter accepts it on the first clock edge where it is idle (busy=0) and
// ignores start at any other time (nothing is queued). done pulses for exactly
// one cycle when D0..D7/overflow carry the new result; those outputs then hold
// until the next done. state mirrors the internal FSM for observation only.
interface sseg_bcd_formatter_if #(
  parameter int IN_BITS = 27
);
  import sseg_pkg::*;

  logic               start;
  logic [IN_BITS-1:0] bin;
  logic [7:0]         dp_mask;
  logic               blank_en;
  logic               busy;
  logic               done;
  logic               overflow;
  logic [5:0]         D0, D1, D2, D3, D4, D5, D6, D7;
  fsm_state_t         state;

  modport master (
    output start, bin, dp_mask, blank_en,
    input  busy, done, overflow, D0, D1, D2, D3, D4, D5, D6, D7, state
  );

  modport slave (
    input  start, bin, dp_mask, blank_en,
    output busy, done, overflow, D0, D1, D2, D3, D4, D5, D6, D7, state
  );

endinterface

// File: rtl/bcd_adj3.sv
// Double-dabble nibble corrector: adds 3 to a BCD nibble that is 5 or more so
// the following left shift carries correctly into the next decade.
module bcd_adj3 (
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  // Add-3 correction applied before each shift
  assign adj = (nib >= 4'd5) ? (nib + 4'd3) : nib;

endmodule

// File: rtl/sseg_bcd_formatter.sv
// Binary-to-8-digit BCD formatter for the seven-segment driver. A serial
// double-dabble engine converts one input bit per cycle; the result is then
// blanked/decorated and loaded into output registers in one cycle so the
// display only ever changes on completion.
module sseg_bcd_formatter
  import sseg_pkg::*;
#(
  parameter int IN_BITS = 27
) (
  input logic             clk,
  input logic             reset_n,
  sseg_bcd_formatter_if.slave bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(IN_BITS);

  fsm_state_t         state;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic [IN_BITS-1:0] bin_sh;
  logic [CNT_W-1:0]   cnt;
  logic [7:0]         dp_q;
  logic               blank_q;
  logic               ovf_cap;
  logic               over;
  logic               busy_q;
  logic               done_q;
  logic               ovf_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] fmt;
  logic               higher_blank;
  logic               higher_dp;
  logic               en;
  logic [3:0]         nib;

  // Values above eight decimal digits saturate to 99_999_999
  assign over = (32'(bus.bin) > 32'(MAX_DEC));

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_adj
      bcd_adj3 u_adj (
        .nib (bcd[4*g +: 4]),
        .adj (bcd_adj[4*g +: 4])
      );
    end
  endgenerate

  // Leading-zero blanking scan from the most significant digit downwards
  always_comb begin
    fmt          = '0;
    higher_blank = 1'b1;
    higher_dp    = 1'b0;
    en           = 1'b1;
    nib          = 4'd0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib = bcd[4*k +: 4];
      en  = 1'b1;
      if (k != 0 && blank_q && nib == 4'd0 && higher_blank && !dp_q[k] && !higher_dp) begin
        en = 1'b0;
      end
      fmt[k][EN_BIT]          = en;
      fmt[k][BCD_MSB:BCD_LSB] = nib;
      fmt[k][DP_BIT]          = dp_q[k];
      higher_blank            = higher_blank & ~en;
      higher_dp               = higher_dp | dp_q[k];
    end
  end

  // Control FSM, conversion datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bcd     <= '0;
      bin_sh  <= '0;
      cnt     <= '0;
      dp_q    <= '0;
      blank_q <= 1'b0;
      ovf_cap <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      digits  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            ovf_cap <= over;
            bin_sh  <= over ? IN_BITS'(MAX_DEC) : bus.bin;
            dp_q    <= bus.dp_mask;
            blank_q <= bus.blank_en;
            bcd     <= '0;
            cnt     <= CNT_W'(IN_BITS - 1);
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd    <= {bcd_adj[BCD_W-2:0], bin_sh[IN_BITS-1]};
          bin_sh <= {bin_sh[IN_BITS-2:0], 1'b0};
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= FORMAT;
          end
        end
        FORMAT: begin
          digits <= fmt;
          ovf_q  <= ovf_cap;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.state    = state;
  assign bus.D0       = digits[0];
  assign bus.D1       = digits[1];
  assign bus.D2       = digits[2];
  assign bus.D3       = digits[3];
  assign bus.D4       = digits[4];
  assign bus.D5       = digits[5];
  assign bus.D6       = digits[6];
  assign bus.D7       = digits[7];

endmodule

// File: tb/tb_sseg_bcd_formatter.sv
// Bench for sseg_bcd_formatter: reset values, a table of hand-worked vectors,
// multi-cycle corner sequences and a random sweep against a decimal model.
module tb_sseg_bcd_formatter;

  localparam int IN_BITS = 27;
  localparam int W       = 49;   // {overflow, D7..D0}

  logic clk;
  logic reset_n;

  sseg_bcd_formatter_if #(.IN_BITS(IN_BITS)) bus ();

  sseg_bcd_formatter #(.IN_BITS(IN_BITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock and done-pulse monitor
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int done_cnt = 0;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;

  typedef struct {
    logic [26:0] bin;
    logic [7:0]  dp;
    logic        bl;
    logic [47:0] exp_d;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[12];

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.overflow, bus.D7, bus.D6, bus.D5, bus.D4, bus.D3, bus.D2, bus.D1, bus.D0};
  endfunction

  // Decimal reference: saturate, split into decimal digits, enable every
  // digit up to the most significant one that is non-zero or carries a dp.
  function automatic logic [W-1:0] model(logic [26:0] b, logic [7:0] m, logic bl);
    int unsigned v;
    int unsigned p;
    int unsigned d[8];
    int          top;
    logic        ov;
    logic [47:0] w;
    ov  = (b > 27'd99_999_999);
    v   = ov ? 99_999_999 : int'(b);
    p   = 1;
    top = 0;
    for (int k = 0; k < 8; k++) begin
      d[k] = (v / p) % 10;
      p    = p * 10;
      if (d[k] != 0 || m[k]) top = k;
    end
    w = '0;
    for (int k = 0; k < 8; k++) begin
      w[6*k +: 6] = {(!bl || k <= top), 4'(d[k]), m[k]};
    end
    return {ov, w};
  endfunction

  // Driver: called at a negedge with the DUT idle (or in DONE when b2b=1).
  // Returns at the negedge where done is seen. noisy=1 keeps toggling start
  // and the data inputs while the conversion runs.
  task automatic convert(input logic [26:0] b, input logic [7:0] m, input logic bl,
                         input bit b2b, input bit noisy, output int lat);
    logic [W-1:0] e;
    bus.start    = 1'b1;
    bus.bin      = b;
    bus.dp_mask  = m;
    bus.blank_en = bl;
    exp_q.push_back(model(b, m, bl));
    if (b2b) begin
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    chk("busy_after_accept", bus.busy, 1'b1);
    chk("hold_during_conv", observed(), last_exp);
    bus.start = noisy ? 1'b1 : 1'b0;
    while (bus.done !== 1'b1 && lat < 200) begin
      if (noisy) begin
        bus.start    = 1'($urandom_range(0, 1));
        bus.bin      = 27'($urandom);
        bus.dp_mask  = 8'($urandom);
        bus.blank_en = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("latency", 64'(lat), 64'(IN_BITS + 2));
    chk("busy_in_done", bus.busy, 1'b1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      chk("result", observed(), e);
      last_exp = e;
    end
  endtask

  int lat;
  int dc0;

  initial begin
    // Hand-worked vectors
    vecs[0]  = '{27'd12_345_678, 8'h00, 1'b0,
                 {6'h22, 6'h24, 6'h26, 6'h28, 6'h2A, 6'h2C, 6'h2E, 6'h30}, 1'b0};
    vecs[1]  = '{27'd305, 8'h00, 1'b1, {{5{6'h00}}, 6'h26, 6'h20, 6'h2A}, 1'b0};
    vecs[2]  = '{27'd0, 8'h00, 1'b1, {{7{6'h00}}, 6'h20}, 1'b0};
    vecs[3]  = '{27'd5, 8'h02, 1'b1, {{6{6'h00}}, 6'h21, 6'h2A}, 1'b0};
    vecs[4]  = '{27'h7FF_FFFF, 8'h00, 1'b0, {8{6'h32}}, 1'b1};
    vecs[5]  = '{27'd42, 8'h00, 1'b0, {{6{6'h20}}, 6'h28, 6'h24}, 1'b0};
    vecs[6]  = '{27'd0, 8'h00, 1'b0, {8{6'h20}}, 1'b0};
    vecs[7]  = '{27'd99_999_999, 8'h00, 1'b1, {8{6'h32}}, 1'b0};
    vecs[8]  = '{27'd100_000_000, 8'h00, 1'b1, {8{6'h32}}, 1'b1};
    vecs[9]  = '{27'd1000, 8'h80, 1'b1,
                 {6'h21, 6'h20, 6'h20, 6'h20, 6'h22, 6'h20, 6'h20, 6'h20}, 1'b0};
    vecs[10] = '{27'd10_000_000, 8'h00, 1'b1, {6'h22, {7{6'h20}}}, 1'b0};
    vecs[11] = '{27'd7, 8'h01, 1'b1, {{7{6'h00}}, 6'h2F}, 1'b0};

    // Reset behaviour
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.bin      = '0;
    bus.dp_mask  = '0;
    bus.blank_en = 1'b0;
    last_exp     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_outputs", observed(), '0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_outputs", observed(), '0);
    chk("post_reset_no_done", 64'(done_cnt), 64'd0);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      convert(vecs[i].bin, vecs[i].dp, vecs[i].bl, 1'b0, 1'b0, lat);
      chk($sformatf("vec%0d_digits", i),
          {bus.D7, bus.D6, bus.D5, bus.D4, bus.D3, bus.D2, bus.D1, bus.D0}, vecs[i].exp_d);
      chk($sformatf("vec%0d_overflow", i), bus.overflow, vecs[i].exp_ovf);
    end

    // Overflow then a normal value back-to-back: flag held until next done
    @(negedge clk);
    convert(27'h7FF_FFFF, 8'h00, 1'b0, 1'b0, 1'b0, lat);
    convert(27'd42, 8'h00, 1'b0, 1'b1, 1'b0, lat);
    chk("ovf_cleared", bus.overflow, 1'b0);

    // start hammered and inputs scrambled while busy: one done, captured value
    @(negedge clk);
    dc0 = done_cnt;
    convert(27'd87_654_321, 8'h10, 1'b1, 1'b0, 1'b1, lat);
    repeat (3) @(negedge clk);
    chk("single_done", 64'(done_cnt - dc0), 64'd1);
    chk("idle_after_noise", bus.busy, 1'b0);

    // Reset mid-SHIFT after an overflowed result: blank outputs, no done
    convert(27'h7FF_FFFF, 8'h55, 1'b0, 1'b0, 1'b0, lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 27'd1234;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    dc0 = done_cnt;
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs", observed(), '0);
    chk("midreset_busy", bus.busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midreset_no_done", 64'(done_cnt - dc0), 64'd0);
    chk("midreset_still_blank", observed(), '0);
    last_exp = '0;

    // Random sweep against the decimal model
    for (int i = 0; i < 1500; i++) begin
      logic [26:0] b;
      logic [7:0]  m;
      logic        bl;
      bit          b2b;
      case ($urandom_range(0, 3))
        0:       b = 27'($urandom_range(0, 999));
        1:       b = 27'($urandom_range(99_999_990, 100_000_010));
        default: b = 27'($urandom);
      endcase
      m   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      bl  = 1'($urandom_range(0, 1));
      b2b = (i > 0) && ($urandom_range(0, 1) == 1);
      if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clk);
      convert(b, m, bl, b2b, 1'b0, lat);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
